iter_shift_unit: RTL and testbench

//  Multi-cycle parametrised shifter for the ALU's shift operations. Successor to the fixed

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 43 ++++
 rtl/iter_shift_unit.sv | 130 +++++++++++++
 tb/tb_iter_shift_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: operation encoding and FSM state encoding.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-cycle combinational shifter covering 0..STEP bit positions.
// Ports:
//   value_i  - current accumulator value
//   k_i      - positions to shift this cycle (0..STEP)
//   op_i     - shift operation
//   fill_i   - bit shifted in from the top for SRA
//   result_o - shifted value
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [KW-1:0]    k_i,
  input  op_e              op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] result_o
);

  logic [2*WIDTH-1:0] wide;

  always_comb begin
    wide     = '0;
    result_o = value_i;
    unique case (op_i)
      OP_SLL: result_o = value_i << k_i;
      OP_SRL: result_o = value_i >> k_i;
      OP_SRA: begin
        wide     = {{WIDTH{fill_i}}, value_i} >> k_i;
        result_o = wide[WIDTH-1:0];
      end
      OP_ROR: begin
        // Upper copy supplies the bits that wrap from LSB into MSB.
        wide     = {value_i, value_i} >> k_i;
        result_o = wide[WIDTH-1:0];
      end
      default: result_o = value_i;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: shifts by a run-time amount, up to STEP positions per cycle,
// behind a valid/ready handshake. FSM: IDLE -> SHIFT -> DONE -> IDLE.
// Build option: define SHIFT_ROTATE_EN to implement op 11 as rotate-right; otherwise
// op 11 completes immediately with out_data = in_data and out_err = 1.
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      - request handshake
//   in_data/in_shamt/in_op - operand, shift amount, operation
//   out_valid/out_ready    - result handshake; result held until accepted
//   out_data/out_err       - result and unsupported-op flag
//   busy                   - unit is not idle
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               busy
);

  localparam int unsigned KW = $clog2(STEP + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  op_e                op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               sign_q, sign_d;
  logic               err_q, err_d;

  logic [31:0]      rem_ext;
  logic [31:0]      k_w;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_res;
  logic             accept;

  // Amount for this cycle: min(remaining, STEP), compared at 32 bits so STEP may exceed
  // the shamt range without truncation.
  assign rem_ext = 32'(rem_q);
  assign k_w     = (rem_ext > STEP) ? STEP : rem_ext;
  assign k       = k_w[KW-1:0];

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .value_i  (acc_q),
    .k_i      (k),
    .op_i     (op_q),
    .fill_i   (sign_q),
    .result_o (step_res)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    err_d   = err_q;

    in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept   = in_valid && in_ready;

    unique case (state_q)
      ST_SHIFT: begin
        acc_d = step_res;
        rem_d = rem_q - SHAMT_W'(k_w);
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Acceptance overrides DONE->IDLE so back-to-back requests have no bubble.
    if (accept) begin
      acc_d  = in_data;
      op_d   = op_e'(in_op);
      rem_d  = in_shamt;
      sign_d = in_data[WIDTH-1];
      err_d  = 1'b0;
      state_d = (in_shamt != '0) ? ST_SHIFT : ST_DONE;
`ifndef SHIFT_ROTATE_EN
      if (op_e'(in_op) == OP_ROR) begin
        err_d   = 1'b1;
        rem_d   = '0;
        state_d = ST_DONE;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      op_q    <= OP_SLL;
      rem_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_data  = acc_q;
  assign out_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: expected results are queued at acceptance and
// compared whenever the DUT hands a result over.
module tb_iter_shift_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  iter_shift_unit #(
    .WIDTH   (32),
    .SHAMT_W (5),
    .STEP    (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: {err, data}.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] sh);
    case (op)
      2'd0: return {1'b0, d << sh};
      2'd1: return {1'b0, d >> sh};
      2'd2: return {1'b0, 32'($signed(d) >>> sh)};
      default: begin
`ifdef SHIFT_ROTATE_EN
        if (sh == 5'd0) return {1'b0, d};
        return {1'b0, (d >> sh) | (d << (6'd32 - {1'b0, sh}))};
`else
        return {1'b1, d};
`endif
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [4:0] sh);
`ifndef SHIFT_ROTATE_EN
    if (op == 2'd3) return 1;
`endif
    return 1 + (int'(sh) + 3) / 4;
  endfunction

  // Result monitor: inputs change only just after posedge, so negedge values are the
  // values the DUT sees at the next edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e[31:0]));
        check("out_err", 64'(out_err), 64'(e[32]));
      end
    end
  end

  // Called just after a posedge; returns at the negedge where out_valid is first seen.
  task automatic do_req(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    logic acc;
    int n;
    int lat;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    n = 0;
    do begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    exp_q.push_back(model(op, d, sh));
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;  // later changes must not affect the result
    in_shamt = 5'd7;
    lat = 1;
    @(negedge clock);
    while (!out_valid && lat < 100) begin
      lat++;
      @(negedge clock);
    end
    check("latency", 64'(lat), 64'(exp_lat(op, sh)));
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    do_req(op, d, sh);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed cases.
    run(2'd0, 32'h0000_00F1, 5'd4);
    run(2'd2, 32'h8000_0000, 5'd31);
    run(2'd1, 32'h8000_0000, 5'd31);
    run(2'd1, 32'h1234_5678, 5'd0);
    run(2'd3, 32'h0000_0001, 5'd1);
    run(2'd2, 32'h7FFF_0000, 5'd9);

    // Random mix.
    for (int i = 0; i < 12; i++) begin
      run(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    do_req(2'd0, 32'h0000_00AB, 5'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", 64'(out_data), 64'h0000_AB00);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    // Back-to-back: new request accepted in the same cycle the result is taken.
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'd0;
    in_data   = 32'h0000_0001;
    in_shamt  = 5'd1;
    @(negedge clock);
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    exp_q.push_back({1'b0, 32'h0000_0002});
    // A request presented during SHIFT must be ignored.
    in_data  = 32'h0000_DEAD;
    in_shamt = 5'd0;
    @(negedge clock);
    check("b2b_gap", 64'(out_valid), 64'd0);
    check("shift_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("b2b_valid", 64'(out_valid), 64'd1);
    @(posedge clock);
    #1;

    // Asynchronous reset in the middle of a long shift.
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_data  = 32'h0000_0001;
    in_shamt = 5'd20;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run(2'd0, 32'h0000_0001, 5'd20);

    repeat (3) @(posedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
